// File: rtl/pc_seq_pkg.sv
// Shared definitions for the fetch-stage PC sequencer: redirect priorities,
// default vectors and the pending-slot merge rule.
package pc_seq_pkg;

  // Redirect priority levels. Higher values win, and the values are compared
  // numerically.
  typedef enum logic [1:0] {
    RDR_NONE = 2'd0,
    RDR_ID   = 2'd1,
    RDR_BR   = 2'd2,
    RDR_EXC  = 2'd3
  } rdr_prio_e;

  localparam int          DEF_WIDTH     = 32;
  localparam int          DEF_STEP      = 4;
  localparam int          DEF_RAS_DEPTH = 4;
  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_4180;

  // A fresh candidate displaces the pending redirect when its priority is at
  // least as high. On a tie the newer request wins.
  function automatic logic cand_wins(rdr_prio_e cand, rdr_prio_e pend);
    return (cand != RDR_NONE) && (cand >= pend);
  endfunction

endpackage

// File: rtl/pc_seq_unit_if.sv
// Request/response bundle between the pipeline control logic (master) and
// the PC sequencer (slave).
interface pc_seq_unit_if #(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic             Stall;
  logic             ExcValid;
  logic             BranchTaken;
  logic [WIDTH-1:0] BranchAddr;
  logic             JumpValid;
  logic [WIDTH-1:0] JumpAddr;
  logic             CallValid;
  logic [WIDTH-1:0] LinkAddr;
  logic             RetValid;
  logic [WIDTH-1:0] PC;
  logic             FlushIfId;
  logic             RetMiss;
  logic [CNT_W-1:0] RasCount;

  modport master (
    output Stall, ExcValid, BranchTaken, BranchAddr, JumpValid, JumpAddr,
           CallValid, LinkAddr, RetValid,
    input  PC, FlushIfId, RetMiss, RasCount
  );

  modport slave (
    input  Stall, ExcValid, BranchTaken, BranchAddr, JumpValid, JumpAddr,
           CallValid, LinkAddr, RetValid,
    output PC, FlushIfId, RetMiss, RasCount
  );

endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack. When the stack is full, a push overwrites
// the oldest entry. A simultaneous pop and push replaces the top entry.
module pc_ras #(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               push,
  input  logic                               pop,
  input  logic [WIDTH-1:0]                   push_data,
  output logic [WIDTH-1:0]                   top,
  output logic [$clog2(RAS_DEPTH+1)-1:0]     count
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [WIDTH-1:0] mem [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_q;      // next free slot
  logic [CNT_W-1:0] cnt_q;
  logic [PTR_W-1:0] top_idx;
  logic [PTR_W-1:0] next_ptr;
  logic             pop_eff;

  // Pointer arithmetic wraps explicitly, so depths that are not a power of
  // two also work.
  always_comb begin
    top_idx  = (ptr_q == '0) ? PTR_W'(RAS_DEPTH - 1) : ptr_q - PTR_W'(1);
    next_ptr = (ptr_q == PTR_W'(RAS_DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
    pop_eff  = pop && (cnt_q != '0);
  end

  // Pointer and occupancy. The count saturates on a push into a full stack,
  // which then overwrites the oldest entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else if (push && pop_eff) begin
      ptr_q <= ptr_q;
      cnt_q <= cnt_q;
    end else if (push) begin
      ptr_q <= next_ptr;
      cnt_q <= (cnt_q == CNT_W'(RAS_DEPTH)) ? cnt_q : cnt_q + CNT_W'(1);
    end else if (pop_eff) begin
      ptr_q <= top_idx;
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Entry storage is data only and is not reset. With pop and push together,
  // the push lands on the slot being popped.
  always_ff @(posedge clk) begin
    if (push) mem[pop_eff ? top_idx : ptr_q] <= push_data;
  end

  assign top   = mem[top_idx];
  assign count = cnt_q;

endmodule

// File: rtl/pc_seq_unit.sv
// Fetch-stage program-counter sequencer. It selects the next PC from the
// exception, branch, ID-stage and sequential sources, holds a redirect that
// arrives while fetch is stalled, and predicts returns with a RAS.
module pc_seq_unit
  import pc_seq_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(DEF_RESET_VEC),
  parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(DEF_EXC_VEC),
  parameter int               STEP      = DEF_STEP,
  parameter int               RAS_DEPTH = DEF_RAS_DEPTH
) (
  input logic          Clk,
  input logic          PcReSet_n,
  pc_seq_unit_if.slave bus
);

  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  // Clear the sub-word bits so every redirect target is STEP-aligned.
  function automatic logic [WIDTH-1:0] align_target(logic [WIDTH-1:0] addr);
    return addr & ~WIDTH'(STEP - 1);
  endfunction

  logic [WIDTH-1:0] pc_q;
  rdr_prio_e        pend_prio_q;
  logic [WIDTH-1:0] pend_tgt_q;
  logic             flush_q;
  logic             miss_q;

  logic             squash;
  logic             id_call;
  logic             id_ret;
  logic             ret_hit;
  logic             ret_miss;
  logic [WIDTH-1:0] ras_top;
  logic [CNT_W-1:0] ras_count;

  rdr_prio_e        cand_prio;
  logic [WIDTH-1:0] cand_tgt;
  rdr_prio_e        mrg_prio;
  logic [WIDTH-1:0] mrg_tgt;

  // An exception or a taken branch squashes every ID-stage request in the
  // same cycle, including any RAS activity that request would cause.
  always_comb begin
    squash   = bus.ExcValid || bus.BranchTaken;
    id_call  = bus.CallValid && !squash;
    id_ret   = bus.RetValid && !squash;
    ret_hit  = id_ret && (ras_count != '0);
    ret_miss = id_ret && (ras_count == '0);
  end

  pc_ras #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (Clk),
    .rst_n     (PcReSet_n),
    .push      (id_call),
    .pop       (id_ret),
    .push_data (bus.LinkAddr),
    .top       (ras_top),
    .count     (ras_count)
  );

  // Pick the highest-priority redirect this cycle. A call or jump outranks a
  // return in the same cycle; a return on an empty RAS gives no redirect.
  always_comb begin
    cand_prio = RDR_NONE;
    cand_tgt  = '0;
    if (bus.ExcValid) begin
      cand_prio = RDR_EXC;
      cand_tgt  = EXC_VEC;
    end else if (bus.BranchTaken) begin
      cand_prio = RDR_BR;
      cand_tgt  = bus.BranchAddr;
    end else if (bus.CallValid || bus.JumpValid) begin
      cand_prio = RDR_ID;
      cand_tgt  = bus.JumpAddr;
    end else if (ret_hit) begin
      cand_prio = RDR_ID;
      cand_tgt  = ras_top;
    end
  end

  // Merge the candidate with the redirect buffered during a stall.
  always_comb begin
    mrg_prio = pend_prio_q;
    mrg_tgt  = pend_tgt_q;
    if (cand_wins(cand_prio, pend_prio_q)) begin
      mrg_prio = cand_prio;
      mrg_tgt  = align_target(cand_tgt);
    end
  end

  // PC register: it holds during a stall and otherwise takes the merged
  // redirect or steps sequentially (wrapping at the top of the space).
  always_ff @(posedge Clk or negedge PcReSet_n) begin
    if (!PcReSet_n) begin
      pc_q <= RESET_VEC;
    end else if (!bus.Stall) begin
      pc_q <= (mrg_prio != RDR_NONE) ? mrg_tgt : pc_q + WIDTH'(STEP);
    end
  end

  // Pending-slot priority: it captures the merged redirect while stalled and
  // is cleared on every unstalled edge.
  always_ff @(posedge Clk or negedge PcReSet_n) begin
    if (!PcReSet_n) begin
      pend_prio_q <= RDR_NONE;
    end else begin
      pend_prio_q <= bus.Stall ? mrg_prio : RDR_NONE;
    end
  end

  // The pending target is data qualified by pend_prio_q, so it needs no reset.
  always_ff @(posedge Clk) begin
    if (bus.Stall) pend_tgt_q <= mrg_tgt;
  end

  // Flush pulses after an exception or branch redirect reaches PC. A miss
  // pulses after an unsquashed return hits an empty RAS.
  always_ff @(posedge Clk or negedge PcReSet_n) begin
    if (!PcReSet_n) begin
      flush_q <= 1'b0;
      miss_q  <= 1'b0;
    end else begin
      flush_q <= !bus.Stall && (mrg_prio >= RDR_BR);
      miss_q  <= ret_miss;
    end
  end

  assign bus.PC        = pc_q;
  assign bus.FlushIfId = flush_q;
  assign bus.RetMiss   = miss_q;
  assign bus.RasCount  = ras_count;

endmodule

// File: tb/tb_pc_seq_unit.sv
// Testbench for pc_seq_unit: directed scenarios followed by random traffic,
// checked against a queue-based reference model.
module tb_pc_seq_unit;

  localparam int          WIDTH = 32;
  localparam int          DEPTH = 4;
  localparam int          STEP  = 4;
  localparam logic [31:0] RVEC  = 32'h0000_3000;
  localparam logic [31:0] EVEC  = 32'h0000_4180;

  logic Clk = 1'b0;
  logic PcReSet_n;
  always #5 Clk = ~Clk;

  pc_seq_unit_if #(.WIDTH(WIDTH), .RAS_DEPTH(DEPTH)) bus ();

  pc_seq_unit #(
    .WIDTH     (WIDTH),
    .RESET_VEC (RVEC),
    .EXC_VEC   (EVEC),
    .STEP      (STEP),
    .RAS_DEPTH (DEPTH)
  ) dut (
    .Clk       (Clk),
    .PcReSet_n (PcReSet_n),
    .bus       (bus)
  );

  // Reference model state
  logic [31:0] m_pc;
  int          m_pend_prio;
  logic [31:0] m_pend_tgt;
  logic        m_flush;
  logic        m_miss;
  logic [31:0] m_ras[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".pc"},    bus.PC,                m_pc);
    check({tag, ".flush"}, 32'(bus.FlushIfId),    32'(m_flush));
    check({tag, ".miss"},  32'(bus.RetMiss),      32'(m_miss));
    check({tag, ".cnt"},   32'(bus.RasCount),     32'(m_ras.size()));
  endtask

  task automatic drive(input logic stall, input logic exc, input logic br, input logic [31:0] baddr,
                       input logic jv, input logic [31:0] jaddr, input logic cv,
                       input logic [31:0] link, input logic rv);
    bus.Stall       = stall;
    bus.ExcValid    = exc;
    bus.BranchTaken = br;
    bus.BranchAddr  = baddr;
    bus.JumpValid   = jv;
    bus.JumpAddr    = jaddr;
    bus.CallValid   = cv;
    bus.LinkAddr    = link;
    bus.RetValid    = rv;
  endtask

  task automatic model_reset();
    m_pc        = RVEC;
    m_pend_prio = 0;
    m_pend_tgt  = '0;
    m_flush     = 1'b0;
    m_miss      = 1'b0;
    m_ras.delete();
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    int          cp;
    logic [31:0] ct;
    int          mp;
    logic [31:0] mt;
    logic        squash;
    squash = bus.ExcValid | bus.BranchTaken;
    cp = 0;
    ct = '0;
    if (bus.ExcValid) begin
      cp = 3; ct = EVEC;
    end else if (bus.BranchTaken) begin
      cp = 2; ct = bus.BranchAddr;
    end else if (bus.CallValid | bus.JumpValid) begin
      cp = 1; ct = bus.JumpAddr;
    end else if (bus.RetValid && m_ras.size() > 0) begin
      cp = 1; ct = m_ras[$];
    end
    ct = ct - (ct % STEP);
    m_miss = !squash && bus.RetValid && (m_ras.size() == 0);
    if (!squash) begin
      if (bus.RetValid && m_ras.size() > 0) void'(m_ras.pop_back());
      if (bus.CallValid) begin
        m_ras.push_back(bus.LinkAddr);
        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
      end
    end
    if (cp != 0 && cp >= m_pend_prio) begin
      mp = cp; mt = ct;
    end else begin
      mp = m_pend_prio; mt = m_pend_tgt;
    end
    if (!bus.Stall) begin
      m_pc        = (mp != 0) ? mt : m_pc + STEP;
      m_flush     = (mp >= 2);
      m_pend_prio = 0;
    end else begin
      m_flush     = 1'b0;
      m_pend_prio = mp;
      m_pend_tgt  = mt;
    end
  endtask

  task automatic step(input string tag, input logic stall, input logic exc, input logic br,
                      input logic [31:0] baddr, input logic jv, input logic [31:0] jaddr,
                      input logic cv, input logic [31:0] link, input logic rv);
    drive(stall, exc, br, baddr, jv, jaddr, cv, link, rv);
    model_edge();
    @(posedge Clk);
    #1;
    check_model(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Assert reset asynchronously between edges, check the immediate effect,
  // hold it across one edge, then release it.
  task automatic do_reset(input string tag);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    PcReSet_n = 1'b0;
    #1;
    model_reset();
    check_model(tag);
    check({tag, ".pc_const"}, bus.PC, RVEC);
    @(posedge Clk);
    #1;
    PcReSet_n = 1'b1;
  endtask

  initial begin
    logic [31:0] link;
    PcReSet_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #2;
    do_reset("reset0");

    // Sequential fetch after reset
    idle("seq1"); check("seq1_const", bus.PC, 32'h3004);
    idle("seq2"); check("seq2_const", bus.PC, 32'h3008);
    idle("seq3"); check("seq3_const", bus.PC, 32'h300C);
    do_reset("reset_mid");

    // A branch squashes a same-cycle jump; its target is aligned down
    step("br_jmp", 0, 0, 1, 32'h3101, 1, 32'h5000, 0, 0, 0);
    check("br_pc", bus.PC, 32'h3100);
    check("br_flush", 32'(bus.FlushIfId), 32'd1);
    idle("br_after");
    check("br_flush_off", 32'(bus.FlushIfId), 32'd0);

    // Stalled redirects merge by priority
    step("stl1", 1, 0, 0, 0, 1, 32'h5000, 0, 0, 0);
    step("stl2", 1, 0, 1, 32'h6000, 0, 0, 0, 0, 0);
    step("stl3", 1, 0, 0, 0, 1, 32'h7000, 0, 0, 0);
    check("stl_hold", bus.PC, 32'h3104);
    idle("stl_rel");
    check("stl_pc", bus.PC, 32'h6000);
    check("stl_flush", 32'(bus.FlushIfId), 32'd1);

    // Five calls overflow the four-entry RAS; five returns drain it
    for (int i = 1; i <= 5; i++) begin
      link = 32'(i * 16);
      step("call", 0, 0, 0, 0, 0, 32'h1000, 1, link, 0);
    end
    check("ras_full", 32'(bus.RasCount), 32'd4);
    step("ret1", 0, 0, 0, 0, 0, 0, 0, 0, 1); check("ret1_pc", bus.PC, 32'h50);
    step("ret2", 0, 0, 0, 0, 0, 0, 0, 0, 1); check("ret2_pc", bus.PC, 32'h40);
    step("ret3", 0, 0, 0, 0, 0, 0, 0, 0, 1); check("ret3_pc", bus.PC, 32'h30);
    step("ret4", 0, 0, 0, 0, 0, 0, 0, 0, 1); check("ret4_pc", bus.PC, 32'h20);
    check("ras_empty", 32'(bus.RasCount), 32'd0);
    step("ret5", 0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("ret5_pc", bus.PC, 32'h24);
    check("ret5_miss", 32'(bus.RetMiss), 32'd1);
    idle("miss_off");
    check("miss_pulse", 32'(bus.RetMiss), 32'd0);

    // A call and a return in the same cycle replace the top entry
    step("c_only", 0, 0, 0, 0, 0, 32'h1000, 1, 32'h10, 0);
    step("c_ret", 0, 0, 0, 0, 0, 32'h2000, 1, 32'h90, 1);
    check("cr_pc", bus.PC, 32'h2000);
    check("cr_cnt", 32'(bus.RasCount), 32'd1);
    step("cr_pop", 0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("cr_top", bus.PC, 32'h90);

    // An exception squashes a same-cycle return
    step("c_again", 0, 0, 0, 0, 0, 32'h1000, 1, 32'h10, 0);
    step("exc_ret", 0, 1, 0, 0, 0, 0, 0, 0, 1);
    check("exc_pc", bus.PC, EVEC);
    check("exc_cnt", 32'(bus.RasCount), 32'd1);

    // Sequential fetch wraps at the top of the address space
    step("to_top", 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0);
    idle("wrap");
    check("wrap_pc", bus.PC, 32'h0);

    // Reset during a stall discards the pending redirect and the RAS
    step("stl_call", 1, 0, 0, 0, 0, 32'h5000, 1, 32'h44, 0);
    do_reset("reset_stall");
    idle("post_rst");
    check("post_rst_pc", bus.PC, 32'h3004);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset("reset_rand");
      step("rand",
           ($urandom_range(0, 9) < 3),
           ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 9) == 0), $urandom(),
           ($urandom_range(0, 6) == 0), $urandom(),
           ($urandom_range(0, 6) == 0), $urandom(),
           ($urandom_range(0, 4) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_seq_unit.md
# pc_seq_unit

Parametrised program-counter sequencer for the fetch stage; successor to the single-mux PC register. Chooses the next fetch address from four prioritised sources: exception, EX-stage branch, ID-stage jump/call/return, and sequential. Buffers a redirect that arrives during a fetch stall. Predicts returns with a small circular return-address stack (RAS).

## Interface
- WIDTH, 32: address width.
- RESET_VEC, 32'h0000_3000: PC value after reset.
- EXC_VEC, 32'h0000_4180: exception handler address.
- STEP, 4: sequential increment; power of two.
- RAS_DEPTH, 4: return-stack entries; ≥2.

Ports:
- Clk  in  1  clock, rising edge.
- PcReSet_n  in  1  asynchronous, active-low reset.
- Stall  in  1  fetch stalled; PC holds.
- ExcValid  in  1  exception redirect to EXC_VEC.
- BranchTaken  in  1  EX-stage taken branch.
- BranchAddr  in  WIDTH  branch target.
- JumpValid  in  1  ID-stage jump.
- JumpAddr  in  WIDTH  jump/call target.
- CallValid  in  1  ID-stage call; redirect to JumpAddr, push LinkAddr.
- LinkAddr  in  WIDTH  return address to push.
- RetValid  in  1  ID-stage return; pop RAS.
- PC  out  WIDTH  current fetch address.
- FlushIfId  out  1  registered; squash IF/ID.
- RetMiss  out  1  registered; return seen with RAS empty.
- RasCount  out  $clog2(RAS_DEPTH+1)  valid RAS entries.

## Operation
- Priority: ExcValid > BranchTaken > {CallValid, JumpValid, RetValid} > sequential.
- CallValid and JumpValid together: treated as a call.
- Squash: ExcValid or BranchTaken squashes every ID-stage request in the same cycle. A squashed request causes no push, no pop and no RetMiss.
- Candidate redirect each cycle: the highest-priority request present this cycle.
- Pending slot (valid, priority, target) merges with the candidate:
  - candidate replaces pending if candidate priority ≥ pending priority (newer wins ties);
  - otherwise pending is kept.
- Posedge with Stall=0:
  - PC ← merged redirect target if one exists, else PC+STEP (mod 2^WIDTH);
  - pending is cleared.
- Posedge with Stall=1:
  - PC holds;
  - the merged redirect is stored in pending.
- Redirect targets have their low log2(STEP) bits forced to zero.
- RAS actions happen in the cycle the request is presented, independent of Stall:
  - Push (call): write LinkAddr at top. When full, overwrite the oldest entry; RasCount saturates at RAS_DEPTH.
  - Pop (return, RasCount>0): target = top entry; RasCount decrements.
  - Return with RasCount=0: no redirect, RetMiss=1 next cycle. ID resolves the target later via JumpValid.
  - Call and return in the same cycle: pop then push, so the top is replaced and RasCount is unchanged.
- FlushIfId=1 for the one cycle after the edge at which an exception or branch redirect was applied to PC.

## Timing
- Reset (PcReSet_n=0, asynchronous):
  - PC=RESET_VEC, pending invalid;
  - RasCount=0, RAS contents don't-care;
  - FlushIfId=0, RetMiss=0.
- After deassertion, the first unstalled edge gives PC=RESET_VEC+STEP.
- Redirect latency: request at edge n (Stall=0) → PC=target after edge n, i.e. one cycle.
- Stalled k cycles: PC is unchanged for k edges; the buffered redirect applies at the first unstalled edge.
- Reset mid-stall discards pending and RAS.
- PC+STEP wraps to 0 at the top of the address space.
- FlushIfId and RetMiss are single-cycle pulses. Both are registered with no combinational input-to-output path.
- PC is a pure register output.

## Structure
- Package pc_seq_pkg holds:
  - redirect-priority encoding: RDR_NONE=0, RDR_ID=1, RDR_BR=2, RDR_EXC=3, compared numerically;
  - the default vector constants.
- Sub-module pc_ras:
  - circular stack parameterised by WIDTH and RAS_DEPTH;
  - ports: push, pop, push_data, top, count;
  - owns the overwrite-oldest rule and the pop-then-push rule.
- Top level holds the priority select, pending slot, PC register and flush/miss registers.

## Test plan
- Reset → PC=0x3000. Release, 3 unstalled edges → 0x3004, 0x3008, 0x300C. Assert reset mid-run → PC=0x3000 immediately.
- BranchTaken=1, BranchAddr=0x3101, same cycle as JumpValid to 0x5000 → PC=0x3100, FlushIfId pulses one cycle, no jump effect.
- Stall=1 for 3 cycles: JumpValid 0x5000 at cycle 1, BranchTaken 0x6000 at cycle 2, JumpValid 0x7000 at cycle 3 → PC holds, then becomes 0x6000 at the first unstalled edge.
- RAS_DEPTH=4: 5 calls with LinkAddr 0x10,0x20,0x30,0x40,0x50, then 5 returns → targets 0x50,0x40,0x30,0x20; RasCount 4→0; the fifth return pulses RetMiss with PC sequential.
- Call+return same cycle with RAS=[0x10], LinkAddr=0x90 → redirect to JumpAddr, top=0x90, RasCount=1. ExcValid same cycle as RetValid → PC=EXC_VEC, RasCount unchanged.
- PC=0xFFFF_FFFC, unstalled → PC=0x0000_0000.
